// File: rtl/regression_seq_ctrl.sv
// Sequencer for the linear-regression coefficient engine: two passes over the
// sample memory with a shared-divider handoff in between.
module regression_seq_ctrl #(
  parameter int N_SAMPLES   = 150,
  parameter int ADDR_W      = 8,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              clr_acc,
  output logic              acc_en,
  output logic              ld_means,
  output logic              div_start,
  input  logic              div_done,
  output logic              ld_b1,
  output logic              ld_b0,
  output logic              err_en,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  localparam int TW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);
  localparam logic [TW-1:0]     LIM  = TW'(DIV_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_ACC, S_DRAIN1, S_DIV_WAIT, S_B0, S_ERR, S_DRAIN2, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              fail_q, fail_d;
  logic              acc_en_q, err_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      tmo_q    <= '0;
      fail_q   <= 1'b0;
      acc_en_q <= 1'b0;
      err_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tmo_q    <= tmo_d;
      fail_q   <= fail_d;
      // data arrives one cycle after the read strobe
      acc_en_q <= (state_q == S_ACC);
      err_en_q <= (state_q == S_ERR);
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = '0;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_INIT;
        fail_d  = 1'b0;
      end
      S_INIT: begin
        addr_d  = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (addr_q == LAST) state_d = S_DRAIN1;
        else                addr_d  = addr_q + ADDR_W'(1);
      end
      S_DRAIN1: state_d = S_DIV_WAIT;
      S_DIV_WAIT: begin
        // div_done on the limit cycle still wins over the timeout
        if (div_done)           state_d = S_B0;
        else if (tmo_q == LIM) begin
          state_d = S_DONE;
          fail_d  = 1'b1;
        end else                tmo_d   = tmo_q + TW'(1);
      end
      S_B0: begin
        addr_d  = '0;
        state_d = S_ERR;
      end
      S_ERR: begin
        if (addr_q == LAST) state_d = S_DRAIN2;
        else                addr_d  = addr_q + ADDR_W'(1);
      end
      S_DRAIN2: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = addr_q;
    mem_rd    = (state_q == S_ACC) || (state_q == S_ERR);
    clr_acc   = (state_q == S_INIT);
    acc_en    = acc_en_q;
    ld_means  = (state_q == S_DRAIN1);
    div_start = (state_q == S_DIV_WAIT) && (tmo_q == '0);
    ld_b1     = (state_q == S_DIV_WAIT) && div_done;
    ld_b0     = (state_q == S_B0);
    err_en    = err_en_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    fail      = fail_q;
  end

endmodule

// File: tb/tb_regression_seq_ctrl.sv
// Directed bench for regression_seq_ctrl: one N=4/timeout-8 instance and one N=1 instance.
module tb_regression_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, dd_a = 1'b0;
  logic       start_b = 1'b0, dd_b = 1'b0;
  logic [7:0] mem_addr_a, mem_addr_b;
  logic       rd_a, clr_a, acc_a, ldm_a, dst_a, ldb1_a, ldb0_a, err_a, busy_a, done_a, fail_a;
  logic       rd_b, clr_b, acc_b, ldm_b, dst_b, ldb1_b, ldb0_b, err_b, busy_b, done_b, fail_b;

  int total = 0;
  int bad   = 0;

  regression_seq_ctrl #(.N_SAMPLES(4), .ADDR_W(8), .DIV_TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .mem_addr(mem_addr_a), .mem_rd(rd_a),
    .clr_acc(clr_a), .acc_en(acc_a), .ld_means(ldm_a), .div_start(dst_a),
    .div_done(dd_a), .ld_b1(ldb1_a), .ld_b0(ldb0_a), .err_en(err_a),
    .busy(busy_a), .done(done_a), .fail(fail_a)
  );

  regression_seq_ctrl #(.N_SAMPLES(1), .ADDR_W(8), .DIV_TIMEOUT(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_b), .mem_addr(mem_addr_b), .mem_rd(rd_b),
    .clr_acc(clr_b), .acc_en(acc_b), .ld_means(ldm_b), .div_start(dst_b),
    .div_done(dd_b), .ld_b1(ldb1_b), .ld_b0(ldb0_b), .err_en(err_b),
    .busy(busy_b), .done(done_b), .fail(fail_b)
  );

  // {clr, rd, acc, ldm, dst, ldb1, ldb0, err, busy, done, fail}
  logic [10:0] va, vb;
  assign va = {clr_a, rd_a, acc_a, ldm_a, dst_a, ldb1_a, ldb0_a, err_a, busy_a, done_a, fail_a};
  assign vb = {clr_b, rd_b, acc_b, ldm_b, dst_b, ldb1_b, ldb0_b, err_b, busy_b, done_b, fail_b};

  // Expected outputs in cycle c (INIT = cycle 1) of a successful run with
  // div_done D cycles after div_start: div_start at n+3, B0 at n+4+D, done at 2n+D+6.
  function automatic logic [10:0] exp_ok(input int c, input int n, input int d);
    logic [10:0] e;
    int s, b0;
    s  = n + 3;
    b0 = n + 4 + d;
    e = '0;
    e[10] = (c == 1);
    e[9]  = (c >= 2 && c <= n + 1) || (c >= b0 + 1 && c <= b0 + n);
    e[8]  = (c >= 3 && c <= n + 2);
    e[7]  = (c == n + 2);
    e[6]  = (c == s);
    e[5]  = (c == s + d);
    e[4]  = (c == b0);
    e[3]  = (c >= b0 + 2 && c <= b0 + n + 1);
    e[2]  = (c >= 1 && c <= b0 + n + 2);
    e[1]  = (c == b0 + n + 2);
    return e;
  endfunction

  function automatic int exp_addr(input int c, input int n, input int d);
    if (c <= n + 1) return c - 2;
    return c - n - d - 5;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if (va !== 11'd0 || mem_addr_a !== 8'd0) begin
      bad++; $display("FAIL reset_a got=%b addr=%0d want=0", va, mem_addr_a);
    end
    total++;
    if (vb !== 11'd0 || mem_addr_b !== 8'd0) begin
      bad++; $display("FAIL reset_b got=%b addr=%0d want=0", vb, mem_addr_b);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  // N=4, D=3; start is also pulsed mid-ERR and must be ignored
  task automatic test_basic();
    @(posedge clk); #1 start_a = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      start_a = (c == 13);
      dd_a    = (c == 10);
      @(negedge clk);
      total++;
      if (va !== exp_ok(c, 4, 3)) begin
        bad++; $display("FAIL basic c=%0d got=%b want=%b", c, va, exp_ok(c, 4, 3));
      end
      if (rd_a || (c >= 6 && c <= 10)) begin
        total++;
        if (mem_addr_a !== 8'(rd_a ? exp_addr(c, 4, 3) : 3)) begin
          bad++; $display("FAIL basic_addr c=%0d got=%0d want=%0d", c, mem_addr_a,
                          rd_a ? exp_addr(c, 4, 3) : 3);
        end
      end
    end
    start_a = 1'b0; dd_a = 1'b0;
  endtask

  task automatic test_timeout();
    logic [10:0] e;
    @(posedge clk); #1 start_a = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      @(negedge clk);
      e = '0;
      e[10] = (c == 1);
      e[9]  = (c >= 2 && c <= 5);
      e[8]  = (c >= 3 && c <= 6);
      e[7]  = (c == 6);
      e[6]  = (c == 7);
      e[2]  = (c <= 15);
      e[1]  = (c == 15);
      e[0]  = (c >= 15);
      total++;
      if (va !== e) begin
        bad++; $display("FAIL timeout c=%0d got=%b want=%b", c, va, e);
      end
    end
  endtask

  // div_done on the 8th DIV_WAIT cycle (D=7); stray pulses in ACC and IDLE.
  // The accepted start also clears the fail left by test_timeout.
  task automatic test_limit();
    @(posedge clk); #1 start_a = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      dd_a    = (c == 3) || (c == 14) || (c == 22);
      @(negedge clk);
      total++;
      if (va !== exp_ok(c, 4, 7)) begin
        bad++; $display("FAIL limit c=%0d got=%b want=%b", c, va, exp_ok(c, 4, 7));
      end
    end
    dd_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 start_a = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      @(negedge clk);
    end
    total++;
    if (mem_addr_a !== 8'd2 || !rd_a) begin
      bad++; $display("FAIL mid_pre addr=%0d rd=%b want addr=2 rd=1", mem_addr_a, rd_a);
    end
    rst = 1'b1;
    #1;
    total++;
    if (va !== 11'd0 || mem_addr_a !== 8'd0) begin
      bad++; $display("FAIL mid_reset got=%b addr=%0d want=0", va, mem_addr_a);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      @(negedge clk);
      total++;
      if (va !== exp_ok(c, 4, 3) || (rd_a && mem_addr_a !== 8'(c - 2))) begin
        bad++; $display("FAIL mid_restart c=%0d got=%b addr=%0d want=%b addr=%0d",
                        c, va, mem_addr_a, exp_ok(c, 4, 3), c - 2);
      end
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // start held high: DONE -> one IDLE cycle -> INIT of the next run
  task automatic test_back_to_back();
    logic [10:0] e;
    @(posedge clk); #1 start_a = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      dd_a = (c == 8);
      @(negedge clk);
      if (c <= 15)       e = exp_ok(c, 4, 1);
      else if (c == 16)  e = '0;
      else               e = 11'b100_0000_0100;
      total++;
      if (va !== e) begin
        bad++; $display("FAIL b2b c=%0d got=%b want=%b", c, va, e);
      end
    end
    start_a = 1'b0; dd_a = 1'b0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_n1();
    int n_rd, n_acc, n_err, done_c;
    n_rd = 0; n_acc = 0; n_err = 0; done_c = 0;
    @(posedge clk); #1 start_b = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      dd_b    = (c == 6);
      @(negedge clk);
      if (rd_b)   n_rd++;
      if (acc_b)  n_acc++;
      if (err_b)  n_err++;
      if (done_b) done_c = c;
      total++;
      if (vb !== exp_ok(c, 1, 2) || (rd_b && mem_addr_b !== 8'd0)) begin
        bad++; $display("FAIL n1 c=%0d got=%b addr=%0d want=%b addr=0",
                        c, vb, mem_addr_b, exp_ok(c, 1, 2));
      end
    end
    dd_b = 1'b0;
    total++;
    if (n_rd != 2 || n_acc != 1 || n_err != 1 || done_c != 10) begin
      bad++; $display("FAIL n1_counts rd=%0d acc=%0d err=%0d done_c=%0d want 2 1 1 10",
                      n_rd, n_acc, n_err, done_c);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_limit();
    test_reset_mid();
    test_back_to_back();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regression_seq_ctrl.md
Name: regression_seq_ctrl

Overview:
- Top-level sequencer for the linear-regression coefficient engine.
- Accepts a start request and walks the sample memory twice:
  - pass 1 accumulates the sums;
  - pass 2 accumulates the error terms.
- Between the passes it hands the B1 division to a shared multi-cycle divider and loads B0.
- Reports done or a divider timeout to the host.

Parameters:
- N_SAMPLES, 150, number of (x,y) samples per run; legal range 1..2^ADDR_W.
- ADDR_W, 8, sample memory address width.
- DIV_TIMEOUT, 64, maximum cycles waited for div_done after div_start.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- mem_addr  out  ADDR_W  sample memory read address (registered).
- mem_rd  out  1  memory read strobe; data valid exactly one cycle later.
- clr_acc  out  1  clear all datapath accumulators and the sample counter.
- acc_en  out  1  accumulate current memory data into the sum registers (pass 1).
- ld_means  out  1  load xbar/ybar registers.
- div_start  out  1  one-cycle pulse that launches the B1 division.
- div_done  in  1  divider result valid, single-cycle pulse.
- ld_b1  out  1  capture divider quotient into B1.
- ld_b0  out  1  load B0 = ybar - B1*xbar.
- err_en  out  1  accumulate the residual of the current sample (pass 2).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse (success or fail).
- fail  out  1  sticky divider-timeout flag.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - state=IDLE; every output is 0; address and timeout counters are 0.
  - An in-flight division is abandoned; a late div_done is ignored.
- States: IDLE, INIT, ACC, DRAIN1, DIV_WAIT, B0, ERR, DRAIN2, DONE.
- IDLE:
  - start=1 at a clock edge moves to INIT and clears fail.
  - start outside IDLE is ignored.
- INIT (1 cycle): clr_acc=1; mem_addr reset to 0.
- ACC (N_SAMPLES cycles):
  - mem_rd=1 with mem_addr=k in cycle k (k=0..N-1).
  - acc_en is mem_rd delayed one cycle (registered).
  - After address N-1 the FSM goes to DRAIN1; mem_addr holds N-1.
- DRAIN1 (1 cycle): acc_en=1 for the last sample; ld_means=1; mem_rd=0.
- DIV_WAIT:
  - div_start=1 only in the entry cycle.
  - The timeout counter counts cycles in the state.
  - When div_done=1: ld_b1=1 in that same cycle, then go to B0.
  - If the counter reaches DIV_TIMEOUT with no div_done: go to DONE with fail set.
  - div_done coinciding with the limit cycle counts as success.
  - div_done outside DIV_WAIT is ignored.
- B0 (1 cycle): ld_b0=1; mem_addr reset to 0.
- ERR: same addressing as ACC, with err_en in place of acc_en.
- DRAIN2 (1 cycle): err_en=1 for the last sample.
- DONE (1 cycle): done=1, then IDLE. fail stays high until the next accepted start.
- Latency: if div_done arrives D cycles after the div_start cycle (D>=1), done is high 2N+D+6 cycles after the edge that sampled start.
- Boundaries:
  - N_SAMPLES=1: ACC and ERR each last 1 cycle.
  - The address counter never wraps past N-1.
  - start held high through DONE re-triggers only after the FSM returns to IDLE.

Test Plan:
- Reset, idle start: N=4, D=3, start pulse → clr_acc 1 cycle; mem_addr 0,1,2,3 with mem_rd; acc_en lagging by 1 cycle; single div_start; ld_b1 with div_done; ld_b0; err_en 4 cycles; done 17 cycles after the start edge; fail=0.
- Timeout: DIV_TIMEOUT=8, div_done never asserted → done pulse after 8 DIV_WAIT cycles; fail=1; no ld_b1/ld_b0/err_en. A following start clears fail.
- Late/limit div_done:
  - div_done exactly at the limit cycle → success path, fail=0.
  - Stray div_done pulses in ACC and IDLE → no effect.
- Reset mid-ACC: assert rst at mem_addr=2 → all outputs 0 immediately; IDLE. Next start restarts from address 0 with clr_acc.
- Start while busy and held high: start toggled during ERR → ignored. start held high continuously → back-to-back runs with exactly 1 IDLE cycle between done and the next INIT.
- N_SAMPLES=1: one mem_rd at address 0, one acc_en, one err_en; done at 2+D+6 cycles after the start edge.
